multicycle_control: RTL

- Moore-style control FSM for the multicycle RISC-V datapath.
- Consumes the datapath's 7-bit opcode output.
- Drives every control input of the datapath: ALUOp, ALUSrcA/B, PCSource, memory, register-file, IR and PC write enables.
- Adds a run gate, an illegal-opcode halt, and retired-instruction and active-cycle counters for bring-up.

---
 rtl/multicycle_control.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle RISC-V datapath, with a run gate,
// a sticky illegal-opcode halt and retired/active-cycle bring-up counters.
//
//   state   | enc | meaning
//   FETCH   |  0  | IR <= mem[PC], PC <= PC+4 (only while run=1)
//   DECODE  |  1  | branch target into ALUOut, dispatch on opcode
//   MEMADDR |  2  | effective address A + imm
//   MEMRD   |  3  | load data read
//   MEMWB   |  4  | load writeback
//   MEMWR   |  5  | store write
//   REXEC   |  6  | R-type ALU op
//   RWB     |  7  | R-type writeback
//   BRANCH  |  8  | compare, conditional PC <= ALUOut
//   HALT    | 15  | illegal opcode seen, sticky until reset
module multicycle_control #(
  parameter logic [6:0] LW    = 7'b0000011,
  parameter logic [6:0] SW    = 7'b0100011,
  parameter logic [6:0] RTYPE = 7'b0110011,
  parameter logic [6:0] BEQ   = 7'b1100011,
  parameter int         CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  output logic [1:0]       ALUOp,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             PCSource,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             halted,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_retired,
  output logic [CNT_W-1:0] active_cycles
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_REXEC   = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_HALT    = 4'd15
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   retire;
  logic   active;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = S_HALT;
    case (state_q)
      S_FETCH:   state_d = run ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode == LW || opcode == SW) state_d = S_MEMADDR;
        else if (opcode == RTYPE)         state_d = S_REXEC;
        else if (opcode == BEQ)           state_d = S_BRANCH;
        else                              state_d = S_HALT;
      end
      S_MEMADDR: state_d = (opcode == LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = S_FETCH;
      S_REXEC:   state_d = S_RWB;
      S_RWB:     state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      default:   state_d = S_HALT;
    endcase
  end

  // FETCH is additionally gated by reset_n so controls are 0 while reset is held.
  always_comb begin
    ALUOp       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (run && reset_n) begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ALUSrcB = 2'b01;
        end
      end
      S_DECODE:  ALUSrcB = 2'b11;
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_REXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB:     RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
      end
      default: ;
    endcase
  end

  assign halted = (state_q == S_HALT);
  assign state  = state_q;
  assign retire = (state_q == S_MEMWB) || (state_q == S_MEMWR) ||
                  (state_q == S_RWB)   || (state_q == S_BRANCH);
  assign active = (state_q != S_HALT) && !((state_q == S_FETCH) && !run);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instr_retired <= '0;
      active_cycles <= '0;
    end else begin
      if (retire) instr_retired <= instr_retired + CNT_W'(1);
      if (active) active_cycles <= active_cycles + CNT_W'(1);
    end
  end

endmodule
